// File: rtl/mci_pkg.sv
// Shared types for the MCI boot sequencer: FSM state encoding and stage limits.
package mci_pkg;

   localparam int unsigned MCI_BOOT_MAX_INIT_STAGES = 8;

   typedef enum logic [3:0] {
      BOOT_IDLE             = 4'd0,
      BOOT_INIT             = 4'd1,
      BOOT_BREAKPOINT       = 4'd2,
      BOOT_MCU              = 4'd3,
      BOOT_WAIT_CLPA_GO     = 4'd4,
      BOOT_CPTRA            = 4'd5,
      BOOT_WAIT_MCU_RST_REQ = 4'd6,
      BOOT_RST_MCU          = 4'd7,
      BOOT_ERROR            = 4'd8,
      BOOT_UNKNOWN          = 4'd9
   } mci_boot_multi_fsm_state_e;

endpackage

// File: rtl/mci_boot_init_chain.sv
// Ordered init/done handshake chain: one stage active at a time, each with an
// optional done timeout; reports chain completion and timeout to the boot FSM.
module mci_boot_init_chain
   import mci_pkg::*;
#(
   parameter int unsigned  NUM_INIT_STAGES     = 2,
   parameter int unsigned  INIT_TIMEOUT_CYCLES = 4096,
   localparam int unsigned IDX_W               = $clog2(NUM_INIT_STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       mci_rst_b,
   input  mci_boot_multi_fsm_state_e  fsm,
   input  logic [NUM_INIT_STAGES-1:0] stage_done,
   output logic [NUM_INIT_STAGES-1:0] stage_init,
   output logic [IDX_W-1:0]           cur_stage,
   output logic                       chain_done,
   output logic                       chain_timeout
);

   localparam int unsigned TO_W = (INIT_TIMEOUT_CYCLES > 0) ? $clog2(INIT_TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TO_W-1:0]  TO_MAX = TO_W'(INIT_TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_INIT_STAGES - 1);

   logic [NUM_INIT_STAGES-1:0] done_meta;
   logic [NUM_INIT_STAGES-1:0] done_sync;
   logic [NUM_INIT_STAGES-1:0] next_init;
   logic [TO_W-1:0]            to_cnt;
   logic                       active;
   logic                       cur_done;
   logic                       is_last;
   logic                       to_hit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge mci_rst_b) begin
      if (!mci_rst_b) begin
         done_meta <= '0;
         done_sync <= '0;
      end else begin
         done_meta <= stage_done;
         done_sync <= done_meta;
      end
   end

   // Only the active stage's done is looked at; the others are masked out.
   assign cur_done      = |(done_sync & (NUM_INIT_STAGES'(1) << cur_stage));
   assign next_init     = NUM_INIT_STAGES'(1) << (cur_stage + IDX_W'(1));
   assign active        = (fsm == BOOT_INIT);
   assign is_last       = (cur_stage == LAST);
   assign to_hit        = (INIT_TIMEOUT_CYCLES != 0) && (to_cnt == TO_MAX);
   assign chain_done    = active && cur_done && is_last;
   assign chain_timeout = active && to_hit && !cur_done;

   always_ff @(posedge clk or negedge mci_rst_b) begin
      if (!mci_rst_b) begin
         stage_init <= '0;
         cur_stage  <= '0;
         to_cnt     <= '0;
      end else if (fsm == BOOT_IDLE) begin
         stage_init <= stage_init | NUM_INIT_STAGES'(1);
         cur_stage  <= '0;
         to_cnt     <= '0;
      end else if (active) begin
         if (cur_done && !is_last) begin
            stage_init <= stage_init | next_init;
            cur_stage  <= cur_stage + IDX_W'(1);
            to_cnt     <= '0;
         end else if (!cur_done && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

endmodule

// File: rtl/mci_boot_seqr_multi.sv
// MCI boot sequencer: runs the init chain, honours the breakpoint, releases
// MCU and Caliptra, then services MCU reset requests with a minimum pulse.
module mci_boot_seqr_multi
   import mci_pkg::*;
#(
   parameter int unsigned  NUM_INIT_STAGES     = 2,
   parameter int unsigned  INIT_TIMEOUT_CYCLES = 4096,
   parameter int unsigned  MIN_MCU_RST_CYCLES  = 15,
   parameter int unsigned  RST_CNT_WIDTH       = 8,
   localparam int unsigned IDX_W               = $clog2(NUM_INIT_STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       mci_rst_b,
   input  logic                       scan_mode,
   input  logic [NUM_INIT_STAGES-1:0] stage_done,
   output logic [NUM_INIT_STAGES-1:0] stage_init,
   input  logic                       mci_boot_seq_brkpoint,
   input  logic                       caliptra_boot_go,
   input  logic                       mcu_rst_req,
   input  logic                       mcu_sram_fw_exec_region_lock,
   output logic                       mcu_rst_b,
   output logic                       cptra_rst_b,
   output logic                       fw_boot_upd_reset,
   output logic                       fw_hitless_upd_reset,
   output logic                       mcu_reset_once,
   output logic [RST_CNT_WIDTH-1:0]   mcu_rst_req_count,
   output mci_boot_multi_fsm_state_e  boot_fsm,
   output logic [IDX_W-1:0]           cur_stage,
   output logic                       init_timeout_err,
   output logic [IDX_W-1:0]           err_stage
);

   localparam int unsigned     RC_W   = $clog2(MIN_MCU_RST_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_MAX = RC_W'(MIN_MCU_RST_CYCLES);

   mci_boot_multi_fsm_state_e state_q;
   logic                      brk_meta;
   logic                      brk_sync;
   logic                      mcu_rst_q;
   logic                      cptra_rst_q;
   logic                      from_rst_q;
   logic [RC_W-1:0]           rst_cnt_q;
   logic                      chain_done;
   logic                      chain_timeout;

   mci_boot_init_chain #(
      .NUM_INIT_STAGES     (NUM_INIT_STAGES),
      .INIT_TIMEOUT_CYCLES (INIT_TIMEOUT_CYCLES)
   ) u_init_chain (
      .clk           (clk),
      .mci_rst_b     (mci_rst_b),
      .fsm           (state_q),
      .stage_done    (stage_done),
      .stage_init    (stage_init),
      .cur_stage     (cur_stage),
      .chain_done    (chain_done),
      .chain_timeout (chain_timeout)
   );

   always_ff @(posedge clk or negedge mci_rst_b) begin
      if (!mci_rst_b) begin
         brk_meta <= 1'b0;
         brk_sync <= 1'b0;
      end else begin
         brk_meta <= mci_boot_seq_brkpoint;
         brk_sync <= brk_meta;
      end
   end

   // Resets are released on the edge entering their release state, so the MCU
   // reset pulse spans exactly the BOOT_RST_MCU residency.
   always_ff @(posedge clk or negedge mci_rst_b) begin
      if (!mci_rst_b) begin
         state_q              <= BOOT_IDLE;
         mcu_rst_q            <= 1'b0;
         cptra_rst_q          <= 1'b0;
         from_rst_q           <= 1'b0;
         rst_cnt_q            <= '0;
         fw_boot_upd_reset    <= 1'b0;
         fw_hitless_upd_reset <= 1'b0;
         mcu_reset_once       <= 1'b0;
         mcu_rst_req_count    <= '0;
         init_timeout_err     <= 1'b0;
         err_stage            <= '0;
      end else begin
         case (state_q)
            BOOT_IDLE: state_q <= BOOT_INIT;
            BOOT_INIT: begin
               if (chain_done) begin
                  state_q <= BOOT_BREAKPOINT;
               end else if (chain_timeout) begin
                  state_q          <= BOOT_ERROR;
                  init_timeout_err <= 1'b1;
                  err_stage        <= cur_stage;
               end
            end
            BOOT_BREAKPOINT: begin
               if (!brk_sync) begin
                  state_q   <= BOOT_MCU;
                  mcu_rst_q <= 1'b1;
               end
            end
            BOOT_MCU: begin
               state_q    <= from_rst_q ? BOOT_WAIT_MCU_RST_REQ : BOOT_WAIT_CLPA_GO;
               from_rst_q <= 1'b0;
            end
            BOOT_WAIT_CLPA_GO: begin
               if (caliptra_boot_go) begin
                  state_q     <= BOOT_CPTRA;
                  cptra_rst_q <= 1'b1;
               end
            end
            BOOT_CPTRA: state_q <= BOOT_WAIT_MCU_RST_REQ;
            BOOT_WAIT_MCU_RST_REQ: begin
               if (mcu_rst_req) begin
                  state_q              <= BOOT_RST_MCU;
                  mcu_rst_q            <= 1'b0;
                  rst_cnt_q            <= '0;
                  fw_boot_upd_reset    <= !mcu_reset_once;
                  fw_hitless_upd_reset <= mcu_reset_once;
                  mcu_reset_once       <= 1'b1;
                  if (mcu_rst_req_count != '1)
                     mcu_rst_req_count <= mcu_rst_req_count + RST_CNT_WIDTH'(1);
               end
            end
            BOOT_RST_MCU: begin
               if (rst_cnt_q != RC_MAX) begin
                  rst_cnt_q <= rst_cnt_q + RC_W'(1);
               end else if (mcu_sram_fw_exec_region_lock) begin
                  state_q    <= BOOT_MCU;
                  mcu_rst_q  <= 1'b1;
                  from_rst_q <= 1'b1;
               end
            end
            BOOT_ERROR:   state_q <= BOOT_ERROR;
            BOOT_UNKNOWN: state_q <= BOOT_UNKNOWN;
            default:      state_q <= BOOT_UNKNOWN;
         endcase
      end
   end

   assign boot_fsm    = state_q;
   assign mcu_rst_b   = scan_mode ? mci_rst_b : mcu_rst_q;
   assign cptra_rst_b = scan_mode ? mci_rst_b : cptra_rst_q;

endmodule

// File: tb/tb_mci_boot_seqr_multi.sv
// Randomized bench for mci_boot_seqr_multi: event timings and status flags are
// predicted arithmetically from the boot rules and compared against two instances.
module tb_mci_boot_seqr_multi;
   import mci_pkg::*;

   localparam int N_MAIN  = 3;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int MIN_RST = 15;
   localparam int TO_B    = 16;

   logic clk = 1'b0;
   logic mci_rst_b, scan_mode, brk, go, req, lock;

   logic [N_MAIN-1:0] stage_done, stage_init;
   logic              mcu_rst_b, cptra_rst_b, fw_boot, fw_hit, once, to_err;
   logic [CNT_W-1:0]  req_cnt;
   logic [1:0]        cur_stage, err_stage;
   mci_boot_multi_fsm_state_e fsm;

   logic [1:0] t_done, t_init, t_cur, t_err_stage;
   logic       t_mcu_rst_b, t_cptra_rst_b, t_fw_boot, t_fw_hit, t_once, t_err;
   logic [7:0] t_cnt;
   mci_boot_multi_fsm_state_e t_fsm;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mci_boot_seqr_multi #(
      .NUM_INIT_STAGES(N_MAIN), .INIT_TIMEOUT_CYCLES(64),
      .MIN_MCU_RST_CYCLES(MIN_RST), .RST_CNT_WIDTH(CNT_W)
   ) dut (
      .clk(clk), .mci_rst_b(mci_rst_b), .scan_mode(scan_mode),
      .stage_done(stage_done), .stage_init(stage_init),
      .mci_boot_seq_brkpoint(brk), .caliptra_boot_go(go), .mcu_rst_req(req),
      .mcu_sram_fw_exec_region_lock(lock), .mcu_rst_b(mcu_rst_b), .cptra_rst_b(cptra_rst_b),
      .fw_boot_upd_reset(fw_boot), .fw_hitless_upd_reset(fw_hit), .mcu_reset_once(once),
      .mcu_rst_req_count(req_cnt), .boot_fsm(fsm), .cur_stage(cur_stage),
      .init_timeout_err(to_err), .err_stage(err_stage)
   );

   mci_boot_seqr_multi #(
      .NUM_INIT_STAGES(2), .INIT_TIMEOUT_CYCLES(TO_B),
      .MIN_MCU_RST_CYCLES(MIN_RST), .RST_CNT_WIDTH(8)
   ) dut_to (
      .clk(clk), .mci_rst_b(mci_rst_b), .scan_mode(scan_mode),
      .stage_done(t_done), .stage_init(t_init),
      .mci_boot_seq_brkpoint(brk), .caliptra_boot_go(go), .mcu_rst_req(req),
      .mcu_sram_fw_exec_region_lock(lock), .mcu_rst_b(t_mcu_rst_b), .cptra_rst_b(t_cptra_rst_b),
      .fw_boot_upd_reset(t_fw_boot), .fw_hitless_upd_reset(t_fw_hit), .mcu_reset_once(t_once),
      .mcu_rst_req_count(t_cnt), .boot_fsm(t_fsm), .cur_stage(t_cur),
      .init_timeout_err(t_err), .err_stage(t_err_stage)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expd);
      n_tests++;
      if (got !== expd) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, expd);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: reset-request bookkeeping and pulse length from the boot rules.
   function automatic int exp_count(input int n_req);
      return (n_req > CNT_MAX) ? CNT_MAX : n_req;
   endfunction

   function automatic int exp_low_cycles(input int lock_lat);
      return (lock_lat + 1 > MIN_RST + 1) ? lock_lat + 1 : MIN_RST + 1;
   endfunction

   task automatic do_reset();
      mci_rst_b = 1'b0;
      scan_mode = 1'b0;
      stage_done = '0;
      t_done = '0;
      brk = 1'b1;
      go = 1'b0;
      req = 1'b0;
      lock = 1'b0;
      step(2);
      mci_rst_b = 1'b1;
   endtask

   // Waits for dut_to to raise stage_init[1]; returns the number of edges taken.
   task automatic wait_t_init1(output int edges);
      edges = -1;
      for (int t = 1; t <= 20; t++) begin
         step(1);
         if (t_init[1]) begin
            edges = t;
            break;
         end
      end
   endtask

   initial begin
      int d, lat, low, j, edges, n_req;
      bit seen;

      // Reset state
      mci_rst_b = 1'b0;
      do_reset();
      mci_rst_b = 1'b0;
      step(1);
      check("rst_fsm", 32'(fsm), 32'(BOOT_IDLE));
      check("rst_mcu_rst_b", mcu_rst_b, 0);
      check("rst_cptra_rst_b", cptra_rst_b, 0);
      check("rst_stage_init", stage_init, 0);
      check("rst_flags", {fw_boot, fw_hit, once, to_err}, 0);
      check("rst_count", req_cnt, 0);
      check("rst_t_fsm", 32'(t_fsm), 32'(BOOT_IDLE));

      // Init chain with random done delays; done[2] raised early must be ignored
      mci_rst_b = 1'b1;
      stage_done[2] = 1'b1;
      step(1);
      check("idle_to_init", 32'(fsm), 32'(BOOT_INIT));
      check("init0_set", stage_init, 3'b001);
      check("cur_stage0", cur_stage, 0);
      for (int i = 0; i < 2; i++) begin
         d = $urandom_range(1, 20);
         step(d);
         check("init_hold_before_done", stage_init, (3'b010 << i) - 3'b001);
         stage_done[i] = 1'b1;
         step(2);
         check("init_not_yet", stage_init, (3'b010 << i) - 3'b001);
         step(1);
         check("init_latency3", stage_init, (3'b100 << i) - 3'b001);
         check("cur_stage_adv", cur_stage, i + 1);
      end
      step(1);
      check("last_done_to_brk", 32'(fsm), 32'(BOOT_BREAKPOINT));

      // Breakpoint hold and release
      step($urandom_range(5, 30));
      check("brk_hold_fsm", 32'(fsm), 32'(BOOT_BREAKPOINT));
      check("brk_hold_mcu", mcu_rst_b, 0);
      brk = 1'b0;
      step(2);
      check("brk_rel_mcu_low", mcu_rst_b, 0);
      step(1);
      check("brk_rel_mcu_high", mcu_rst_b, 1);
      check("brk_rel_fsm_mcu", 32'(fsm), 32'(BOOT_MCU));
      step(1);
      check("wait_clpa_go", 32'(fsm), 32'(BOOT_WAIT_CLPA_GO));

      // mcu_rst_req ignored before Caliptra is released
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(1);
      check("req_ignored_fsm", 32'(fsm), 32'(BOOT_WAIT_CLPA_GO));
      check("req_ignored_cnt", req_cnt, 0);
      check("cptra_still_rst", cptra_rst_b, 0);
      go = 1'b1;
      step(1);
      go = 1'b0;
      check("cptra_fsm", 32'(fsm), 32'(BOOT_CPTRA));
      check("cptra_released", cptra_rst_b, 1);
      step(1);
      check("wait_req_fsm", 32'(fsm), 32'(BOOT_WAIT_MCU_RST_REQ));

      // MCU reset requests, random lock latency, counter saturation
      n_req = 0;
      for (int k = 0; k < 9; k++) begin
         step($urandom_range(1, 5));
         if (k == 2) lat = 40;
         else if ($urandom_range(0, 1) == 0) lat = 0;
         else lat = $urandom_range(1, 30);
         lock = (lat == 0);
         req = 1'b1;
         step(1);
         req = 1'b0;
         n_req++;
         check("req_fsm_rst", 32'(fsm), 32'(BOOT_RST_MCU));
         check("req_mcu_low", mcu_rst_b, 0);
         check("req_fw_boot", fw_boot, (n_req == 1) ? 1 : 0);
         check("req_fw_hitless", fw_hit, (n_req > 1) ? 1 : 0);
         check("req_once", once, 1);
         check("req_count", req_cnt, exp_count(n_req));
         low = 1;
         j = 0;
         seen = 1'b0;
         for (int t = 0; t < 200; t++) begin
            if (j == lat) lock = 1'b1;
            step(1);
            j++;
            if (mcu_rst_b) begin
               seen = 1'b1;
               break;
            end
            low++;
         end
         check("rst_release_seen", seen, 1);
         check("rst_low_cycles", low, exp_low_cycles(lat));
         check("rst_exit_fsm", 32'(fsm), 32'(BOOT_MCU));
         step(1);
         lock = 1'b0;
         check("back_to_wait", 32'(fsm), 32'(BOOT_WAIT_MCU_RST_REQ));
         check("flags_held", {fw_boot, fw_hit}, (n_req == 1) ? 2'b10 : 2'b01);
      end

      // Asynchronous reset in BOOT_RST_MCU with the pulse counter at 5
      lock = 1'b1;
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(5);
      check("pre_async_fsm", 32'(fsm), 32'(BOOT_RST_MCU));
      #2 mci_rst_b = 1'b0;
      #1;
      check("async_fsm", 32'(fsm), 32'(BOOT_IDLE));
      check("async_resets", {mcu_rst_b, cptra_rst_b}, 0);
      check("async_flags", {fw_boot, fw_hit, once, to_err}, 0);
      check("async_count", req_cnt, 0);
      check("async_stage_init", stage_init, 0);

      // Scan mode: resets follow mci_rst_b
      scan_mode = 1'b1;
      #1;
      check("scan_rst_low", {mcu_rst_b, cptra_rst_b}, 2'b00);
      stage_done = '0;
      brk = 1'b1;
      lock = 1'b0;
      mci_rst_b = 1'b1;
      #1;
      check("scan_rst_high", {mcu_rst_b, cptra_rst_b}, 2'b11);
      scan_mode = 1'b0;
      #1;
      check("scan_off", {mcu_rst_b, cptra_rst_b}, 2'b00);

      // Stage 1 timeout on the N=2 instance
      do_reset();
      t_done[0] = 1'b1;
      wait_t_init1(edges);
      check("t_init1_latency", edges, 3);
      step(TO_B);
      check("t_before_timeout", 32'(t_fsm), 32'(BOOT_INIT));
      check("t_err_before", t_err, 0);
      step(1);
      check("t_timeout_fsm", 32'(t_fsm), 32'(BOOT_ERROR));
      check("t_timeout_err", t_err, 1);
      check("t_err_stage", t_err_stage, 1);
      t_done[1] = 1'b1;
      brk = 1'b0;
      go = 1'b1;
      step(6);
      check("t_error_terminal", 32'(t_fsm), 32'(BOOT_ERROR));
      check("t_error_resets", {t_mcu_rst_b, t_cptra_rst_b}, 0);

      // Done arriving on the timeout cycle wins
      do_reset();
      t_done[0] = 1'b1;
      wait_t_init1(edges);
      check("t2_init1_latency", edges, 3);
      step(TO_B - 2);
      t_done[1] = 1'b1;
      step(2);
      check("t2_still_init", 32'(t_fsm), 32'(BOOT_INIT));
      step(1);
      check("t2_done_wins", 32'(t_fsm), 32'(BOOT_BREAKPOINT));
      check("t2_no_err", t_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
      $fatal(1);
   end

endmodule
